// File: rtl/cbus_pkg.sv
// Shared types and constants for the cache-bus to AXI3 bridge.
// CBus data/strobe fields are sized for the widest supported bus; narrower builds use the low bits.
package cbus_pkg;

  localparam int unsigned CBUS_MAX_DATA_W = 64;
  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;

  typedef struct packed {
    logic                           valid;
    logic                           is_write;
    logic [2:0]                     size;
    logic [31:0]                    addr;
    logic [CBUS_MAX_DATA_W/8-1:0]   strobe;
    logic [CBUS_MAX_DATA_W-1:0]     data;
    logic [3:0]                     len;
  } cbus_req_t;

  typedef struct packed {
    logic                       ready;
    logic                       last;
    logic [CBUS_MAX_DATA_W-1:0] data;
  } cbus_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } bridge_state_t;

endpackage

// File: rtl/cbus_axi_bridge_if.sv
// AXI3 channel bundle between the bridge (master) and the interconnect (slave).
interface cbus_axi_bridge_if #(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned DATA_W = 32
);
  logic [ID_W-1:0]     arid;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/cbus_axi_bridge_beat_counter.sv
// Write beat counter: loaded with beats-1 at acceptance, advanced per W handshake.
module axi_beat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] len,
  input  logic       inc,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (inc) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign last = (cnt_q == len_q);

endmodule

// File: rtl/cbus_axi_bridge.sv
// Converts one CBus transaction (single beat or INCR burst) into AXI3 master activity.
// One transaction outstanding; sticky bus_err on non-OKAY responses or oversized len.
module cbus_axi_bridge
  import cbus_pkg::*;
#(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned AXI_ID  = 0,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  cbus_req_t                creq,
  output cbus_resp_t               cresp,
  output logic                     bus_err,
  input  logic                     err_clr,
  cbus_axi_bridge_if.master        axi
);

  localparam logic [ID_W-1:0] ID        = ID_W'(AXI_ID);
  localparam logic [4:0]      MAX_LEN_W = 5'(MAX_LEN);
  localparam logic [3:0]      LEN_CLAMP = 4'(MAX_LEN - 1);

  bridge_state_t state_q, state_d;

  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [3:0]  len_q;
  logic [1:0]  burst_q;

  logic       accept;
  logic       len_over;
  logic [3:0] len_eff;
  logic       r_beat;
  logic       w_hs;
  logic       w_last;
  logic       b_hs;
  logic       err_set;
  logic       unused_hi_bits;

  assign accept   = (state_q == ST_IDLE) && creq.valid;
  assign len_over = ({1'b0, creq.len} >= MAX_LEN_W);
  assign len_eff  = len_over ? LEN_CLAMP : creq.len;

  // Responses carrying a foreign id are consumed (rready/bready high) but otherwise ignored.
  assign r_beat = (state_q == ST_R) && axi.rvalid && (axi.rid == ID);
  assign w_hs   = (state_q == ST_W) && axi.wready;
  assign b_hs   = (state_q == ST_B) && axi.bvalid && (axi.bid == ID);

  assign err_set = (accept && len_over)
                 || (r_beat && (axi.rresp != AXI_RESP_OKAY))
                 || (b_hs   && (axi.bresp != AXI_RESP_OKAY));

  assign unused_hi_bits = ^{creq.data, creq.strobe};

  axi_beat_counter u_beat_cnt (
    .clk   (aclk),
    .rst_n (aresetn),
    .load  (accept),
    .len   (len_eff),
    .inc   (w_hs),
    .last  (w_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (creq.valid)        state_d = creq.is_write ? ST_AW : ST_AR;
      ST_AR:   if (axi.arready)       state_d = ST_R;
      ST_R:    if (r_beat && axi.rlast) state_d = ST_IDLE;
      ST_AW:   if (axi.awready)       state_d = ST_W;
      ST_W:    if (w_hs && w_last)    state_d = ST_B;
      ST_B:    if (b_hs)              state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wlast   = 1'b0;
    axi.bready  = 1'b0;
    cresp       = '0;
    unique case (state_q)
      ST_AR: axi.arvalid = 1'b1;
      ST_R: begin
        axi.rready = 1'b1;
        if (r_beat) begin
          cresp.ready             = 1'b1;
          cresp.last              = axi.rlast;
          cresp.data[DATA_W-1:0]  = axi.rdata;
        end
      end
      ST_AW: axi.awvalid = 1'b1;
      ST_W: begin
        axi.wvalid  = 1'b1;
        axi.wdata   = creq.data[DATA_W-1:0];
        axi.wstrb   = creq.strobe[DATA_W/8-1:0];
        axi.wlast   = w_last;
        cresp.ready = w_hs && !w_last;
      end
      ST_B: begin
        axi.bready = 1'b1;
        if (b_hs) begin
          cresp.ready = 1'b1;
          cresp.last  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q  <= '0;
      size_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
    end else if (accept) begin
      addr_q  <= creq.addr;
      size_q  <= creq.size;
      len_q   <= len_eff;
      burst_q <= AXI_BURST_INCR;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus_err <= 1'b0;
    end else if (err_set) begin
      bus_err <= 1'b1;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

  assign axi.arid    = ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = burst_q;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;

  assign axi.awid    = ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = len_q;
  assign axi.awsize  = size_q;
  assign axi.awburst = burst_q;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;

  assign axi.wid     = ID;

endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Directed + randomized bench for cbus_axi_bridge acting as requester and AXI slave.
module tb_cbus_axi_bridge;
  import cbus_pkg::*;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned AXI_ID  = 3;
  localparam int unsigned DATA_W  = 32;
  localparam int          MAX_LEN = 8;
  localparam logic [3:0]  MY_ID   = 4'd3;
  localparam logic [3:0]  FOREIGN = 4'd5;

  logic       aclk;
  logic       aresetn;
  cbus_req_t  creq;
  cbus_resp_t cresp;
  logic       bus_err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;
  bit err_exp = 1'b0;

  cbus_axi_bridge_if #(.ID_W(ID_W), .DATA_W(DATA_W)) axi ();

  cbus_axi_bridge #(
    .ID_W    (ID_W),
    .AXI_ID  (AXI_ID),
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .creq    (creq),
    .cresp   (cresp),
    .bus_err (bus_err),
    .err_clr (err_clr),
    .axi     (axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int len);
    return (len >= MAX_LEN) ? MAX_LEN - 1 : len;
  endfunction

  task automatic slave_idle();
    axi.arready = 0; axi.awready = 0; axi.wready = 0;
    axi.rvalid = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input int ar_delay, input int gap, input int foreign_at,
                         input int err_beat, input bit clr_on_err);
    int eff;
    logic [31:0] data;
    logic [1:0]  resp;
    eff = eff_len(len);
    if (len >= MAX_LEN) err_exp = 1'b1;
    creq = '0;
    creq.valid = 1'b1; creq.addr = addr; creq.len = 4'(len); creq.size = size;
    @(negedge aclk); #1;
    chk("ar_valid", axi.arvalid, 1);
    chk("ar_addr", axi.araddr, addr);
    chk("ar_len", axi.arlen, eff);
    chk("ar_size", axi.arsize, size);
    chk("ar_burst", axi.arburst, 2'b01);
    for (int d = 0; d < ar_delay; d++) begin
      @(negedge aclk); #1;
      chk("ar_hold", axi.arvalid, 1);
    end
    axi.arready = 1;
    @(negedge aclk);
    axi.arready = 0; #1;
    chk("ar_drop", axi.arvalid, 0);
    chk("r_ready", axi.rready, 1);
    for (int b = 0; b <= eff; b++) begin
      for (int g = 0; g < gap; g++) begin
        axi.rvalid = 0; #1;
        chk("r_gap_noresp", cresp.ready, 0);
        @(negedge aclk);
      end
      if (b == foreign_at) begin
        axi.rvalid = 1; axi.rid = FOREIGN; axi.rdata = $urandom; axi.rresp = 2'b11; axi.rlast = 1;
        #1;
        chk("r_foreign_noresp", cresp.ready, 0);
        @(negedge aclk);
      end
      data = $urandom;
      resp = (b == err_beat) ? 2'b10 : 2'b00;
      if (clr_on_err && b == err_beat) err_clr = 1;
      axi.rvalid = 1; axi.rid = MY_ID; axi.rdata = data; axi.rresp = resp; axi.rlast = (b == eff);
      #1;
      chk("r_beat_ready", cresp.ready, 1);
      chk("r_beat_data", cresp.data, {32'd0, data});
      chk("r_beat_last", cresp.last, (b == eff));
      if (resp != 2'b00) err_exp = 1'b1;
      @(negedge aclk);
      err_clr = 0;
    end
    axi.rvalid = 0; axi.rlast = 0; axi.rresp = 0; creq.valid = 0;
    #1;
    chk("r_done_noresp", cresp.ready, 0);
    chk("r_done_idle", axi.rready, 0);
    chk("r_bus_err", bus_err, err_exp);
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input int aw_delay, input int b_delay, input logic [1:0] bresp,
                          input int wmode, input int rst_at_beat);
    int eff;
    int beat;
    bit wr;
    logic [31:0] wd [17];
    logic [3:0]  ws [17];
    eff = eff_len(len);
    if (len >= MAX_LEN) err_exp = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'($urandom_range(1, 15));
    end
    creq = '0;
    creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = addr; creq.len = 4'(len);
    creq.size = size; creq.data = 64'(wd[0]); creq.strobe = 8'(ws[0]);
    @(negedge aclk); #1;
    chk("aw_valid", axi.awvalid, 1);
    chk("aw_addr", axi.awaddr, addr);
    chk("aw_len", axi.awlen, eff);
    chk("aw_burst", axi.awburst, 2'b01);
    chk("aw_w_early", axi.wvalid, 0);
    for (int d = 0; d < aw_delay; d++) begin
      @(negedge aclk); #1;
      chk("aw_hold", axi.awvalid, 1);
      chk("aw_w_early", axi.wvalid, 0);
    end
    axi.awready = 1; #1;
    chk("aw_w_overlap", axi.wvalid, 0);
    @(negedge aclk);
    axi.awready = 0; #1;
    chk("aw_drop", axi.awvalid, 0);
    beat = 0;
    for (int c = 0; c < 200 && beat <= eff; c++) begin
      if (beat == rst_at_beat) begin
        aresetn = 0; #1;
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_wlast", axi.wlast, 0);
        chk("rst_wdata", axi.wdata, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_cresp_ready", cresp.ready, 0);
        chk("rst_cresp_last", cresp.last, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_awaddr", axi.awaddr, 0);
        chk("rst_awlen", axi.awlen, 0);
        err_exp = 1'b0;
        creq = '0;
        slave_idle();
        @(negedge aclk); @(negedge aclk);
        aresetn = 1; #1;
        chk("post_rst_idle", axi.awvalid | axi.wvalid | axi.arvalid, 0);
        return;
      end
      case (wmode)
        0:       wr = 1'b1;
        1:       wr = (c % 2 == 0);
        default: wr = ($urandom_range(0, 3) != 0);
      endcase
      axi.wready = wr; #1;
      chk("w_valid", axi.wvalid, 1);
      chk("w_data", axi.wdata, wd[beat]);
      chk("w_strb", axi.wstrb, ws[beat]);
      chk("w_last", axi.wlast, (beat == eff));
      chk("w_aw_overlap", axi.awvalid, 0);
      chk("w_cresp_ready", cresp.ready, (wr && beat < eff));
      chk("w_cresp_last", cresp.last, 0);
      @(negedge aclk);
      if (wr) begin
        beat++;
        creq.data = 64'(wd[beat]);
        creq.strobe = 8'(ws[beat]);
      end
    end
    chk("w_beat_count", beat, eff + 1);
    axi.wready = 0;
    for (int d = 0; d < b_delay; d++) begin
      if (d == 0) begin
        axi.bvalid = 1; axi.bid = FOREIGN; axi.bresp = 2'b11;
      end else begin
        axi.bvalid = 0;
      end
      #1;
      chk("b_ready", axi.bready, 1);
      chk("b_wait_noresp", cresp.ready, 0);
      @(negedge aclk);
    end
    axi.bvalid = 1; axi.bid = MY_ID; axi.bresp = bresp; #1;
    chk("b_resp_ready", cresp.ready, 1);
    chk("b_resp_last", cresp.last, 1);
    if (bresp != 2'b00) err_exp = 1'b1;
    @(negedge aclk);
    axi.bvalid = 0; axi.bresp = 0; creq.valid = 0; #1;
    chk("b_done_noresp", cresp.ready, 0);
    chk("b_done_idle", axi.bready, 0);
    chk("w_bus_err", bus_err, err_exp);
  endtask

  task automatic clear_err();
    err_clr = 1;
    @(negedge aclk);
    err_clr = 0;
    err_exp = 1'b0;
    #1;
    chk("err_clr", bus_err, 0);
  endtask

  initial begin
    aresetn = 0;
    err_clr = 0;
    creq = '0;
    slave_idle();
    @(negedge aclk); @(negedge aclk); #1;
    chk("reset_cresp_ready", cresp.ready, 0);
    chk("reset_cresp_last", cresp.last, 0);
    chk("reset_cresp_data", cresp.data, 0);
    chk("reset_bus_err", bus_err, 0);
    chk("reset_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 0);
    chk("reset_ar_fields", {axi.araddr, axi.arlen, axi.arsize, axi.arburst}, 0);
    chk("reset_aw_fields", {axi.awaddr, axi.awlen, axi.awsize, axi.awburst}, 0);
    aresetn = 1;
    @(negedge aclk);

    do_read(32'h0000_1000, 0, 3'd2, 2, 0, -1, -1, 0);
    do_read($urandom & 32'hFFFF_FFF0, 3, 3'd2, 1, 1, -1, -1, 0);
    do_write($urandom & 32'hFFFF_FFE0, 7, 3'd2, 1, 1, 2'b00, 1, -1);

    do_read(32'h0000_2000, 0, 3'd2, 0, 0, -1, 0, 0);
    do_read(32'h0000_2004, 1, 3'd2, 0, 0, -1, -1, 0);
    clear_err();
    do_read(32'h0000_2008, 0, 3'd2, 1, 0, -1, 0, 1);
    do_write(32'h0000_3000, 2, 3'd2, 0, 2, 2'b10, 0, -1);

    do_write(32'h0000_4000, 3, 3'd2, 0, 0, 2'b00, 0, 1);
    do_read(32'h0000_5000, 0, 3'd2, 0, 0, -1, -1, 0);

    do_read(32'h0000_6000, 1, 3'd2, 0, 0, 1, -1, 0);
    do_read(32'h0000_6100, 0, 3'd2, 0, 0, 0, -1, 0);

    do_read(32'h0000_7000, 12, 3'd2, 0, 0, -1, -1, 0);
    clear_err();
    do_write(32'h0000_7100, 15, 3'd2, 0, 1, 2'b00, 2, -1);
    clear_err();

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write($urandom & 32'hFFFF_FFFC, $urandom_range(0, 9), 3'($urandom_range(0, 2)),
                 $urandom_range(0, 3), $urandom_range(0, 2),
                 ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00, $urandom_range(0, 2), -1);
      end else begin
        do_read($urandom & 32'hFFFF_FFFC, $urandom_range(0, 9), 3'($urandom_range(0, 2)),
                $urandom_range(0, 3), $urandom_range(0, 1),
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
                ($urandom_range(0, 5) == 0) ? 0 : -1, 0);
      end
      if (err_exp) clear_err();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
